param_load_unit: RTL and testbench
==================================

Name: param_load_unit

Overview:
- Parametrised load unit that turns a byte-addressed load request into a word read on a backing memory port.
- Extracts the addressed byte, half, word or dword from the returned word and sign- or zero-extends it to XLEN.
- Returns the result on a valid/ready response channel with an error code.
- Sits between the execute stage and the data memory or register-backed store. Replaces the fixed 64-bit, 32-entry, always-ready load path with handshakes, access sizes, fault detection and a timeout.

Parameters:
- XLEN, 64, data width in bits; legal values 32 or 64; BYTES = XLEN/8.
- ADDR_W, 64, request byte-address width.
- MEM_DEPTH, 32, number of XLEN-wide words in backing memory; IDX_W = clog2(MEM_DEPTH).
- TIMEOUT, 15, maximum cycles in WAIT before a timeout fault; must be at least 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- req_unsigned  in  1  1=zero-extend, 0=sign-extend.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_word_addr  out  IDX_W  word index = req_addr >> log2(BYTES).
- mem_resp_valid  in  1  memory read data valid.
- mem_rdata  in  XLEN  memory read word, little-endian.
- resp_valid  out  1  load result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  XLEN  extended load result; 0 on any error.
- resp_err  out  2  0=ok, 1=misaligned/illegal size, 2=out of range, 3=timeout.

Behaviour:
- Reset: asynchronous assert forces state IDLE.
  - mem_req_valid=0, resp_valid=0, resp_data=0, resp_err=0, mem_word_addr=0, timeout counter=0.
  - req_ready=0 while reset is high.
  - Reset mid-transaction drops that transaction with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- req_ready = (state==IDLE) && !reset. It is the only accept point: one outstanding load.
- IDLE: on req_valid, latch addr, size and unsigned; compute checks in the same cycle.
  - Misaligned: addr mod (1<<size) != 0, or (1<<size) > BYTES. Gives err 1.
  - Out of range: (addr >> log2(BYTES)) >= MEM_DEPTH. Gives err 2.
  - Priority: misaligned over range.
  - On error: go to RESP with resp_data=0 and the error code. The memory port is never touched.
  - Otherwise: go to ISSUE.
- ISSUE: mem_req_valid=1 and mem_word_addr held stable until mem_req_ready. On the handshake cycle, go to WAIT and clear the counter.
- WAIT: counter increments each cycle.
  - mem_resp_valid: capture the lane at byte offset addr mod BYTES (bits [8*off +: 8<<size]), extend per req_unsigned to XLEN, err=0, go to RESP.
  - Counter reaches TIMEOUT with no response: err=3, data=0, go to RESP.
  - mem_resp_valid in the same cycle the counter hits TIMEOUT: the response wins.
- RESP: resp_valid=1; resp_data and resp_err held stable until resp_ready. On the handshake cycle, go to IDLE and drop resp_valid next cycle.
- Stray mem_resp_valid outside WAIT, including a late response after a timeout, is ignored.
- Latency:
  - Error path: resp_valid is high 1 cycle after acceptance.
  - Zero-wait memory (mem_req_ready=1, response in the first WAIT cycle): resp_valid is high 3 cycles after acceptance.
- Throughput: after a response handshake the unit is back in IDLE the next cycle, so the minimum spacing between accepts is 4 cycles with no errors.

Test Plan:
- Setup: XLEN=64, MEM_DEPTH=32, word 1 = 0x8877665544332211.
- Signed byte at addr 0x0F, zero-wait memory -> mem_word_addr=1; resp_valid 3 cycles after accept; resp_data=0xFFFFFFFFFFFFFF88, resp_err=0.
- Unsigned half at 0x0A -> resp_data=0x0000000000004433. Signed word at 0x0C -> 0xFFFFFFFF88776655.
- Word at 0x06 -> resp_err=1 and resp_data=0 one cycle after accept; mem_req_valid never asserts. Dword at 0x100 -> resp_err=2.
- mem_req_ready held low 4 cycles, then the memory never responds -> mem_req_valid held with a stable address for 5 cycles; resp_err=3 after 15 WAIT cycles. A later stray mem_resp_valid changes nothing.
- resp_ready low 5 cycles in RESP -> resp_valid, resp_data and resp_err stable; req_ready=0 throughout. A new request is accepted the cycle after the handshake.
- reset pulsed mid-WAIT -> all outputs 0 immediately; no resp_valid; after release req_ready=1 and the next load completes correctly.

Source files
------------

// File: rtl/param_load_unit.sv
// Load unit: accepts one byte-addressed load at a time, reads the containing word
// from a handshaked memory port, and returns the extended lane or an error code.
module param_load_unit #(
  parameter int XLEN      = 64,
  parameter int ADDR_W    = 64,
  parameter int MEM_DEPTH = 32,
  parameter int TIMEOUT   = 15,
  localparam int BYTES    = XLEN / 8,
  localparam int IDX_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [IDX_W-1:0]  mem_word_addr,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [1:0]        resp_err
);

  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [CNT_W-1:0]  count;
  logic [3:0]        size_bytes;
  logic [ADDR_W-1:0] align_mask;
  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              accept;
  logic              timed_out;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   lane_mask;
  logic [XLEN-1:0]   lane_ext;
  logic [6:0]        lane_bits;
  logic              sign_bit;

  // Request checks are evaluated combinationally so the accept cycle already knows the outcome.
  always_comb begin
    size_bytes   = 4'd1 << req_size;
    align_mask   = ADDR_W'(size_bytes) - ADDR_W'(1);
    word_idx     = req_addr >> OFF_W;
    misaligned   = ((req_addr & align_mask) != '0) || (size_bytes > 4'(BYTES));
    out_of_range = word_idx >= ADDR_W'(MEM_DEPTH);
    req_err      = misaligned || out_of_range;
  end

  assign accept    = req_valid && req_ready;
  assign timed_out = (count == CNT_LAST);

  // A dword lane shifts the all-ones pattern fully out, leaving a full-width mask.
  always_comb begin
    shifted   = mem_rdata >> {off_q, 3'b000};
    lane_bits = 7'd8 << size_q;
    lane_mask = ~({XLEN{1'b1}} << lane_bits);
    case (size_q)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase
    lane_ext = (shifted & lane_mask) | ({XLEN{sign_bit && !unsigned_q}} & ~lane_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_err ? RESP : ISSUE;
      ISSUE:   if (mem_req_ready) state_next = WAIT;
      WAIT:    if (mem_resp_valid || timed_out) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state == IDLE) && !reset;
    mem_req_valid = (state == ISSUE);
    resp_valid    = (state == RESP);
  end

  // A response arriving on the last WAIT cycle takes precedence over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      off_q         <= '0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      count         <= '0;
      mem_word_addr <= '0;
      resp_data     <= '0;
      resp_err      <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            off_q      <= req_addr[OFF_W-1:0];
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            if (req_err) begin
              resp_data <= '0;
              resp_err  <= misaligned ? 2'd1 : 2'd2;
            end else begin
              mem_word_addr <= word_idx[IDX_W-1:0];
            end
          end
        end
        ISSUE: begin
          if (mem_req_ready) count <= '0;
        end
        WAIT: begin
          count <= count + 1'b1;
          if (mem_resp_valid) begin
            resp_data <= lane_ext;
            resp_err  <= 2'd0;
          end else if (timed_out) begin
            resp_data <= '0;
            resp_err  <= 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_load_unit.sv
// Bench for param_load_unit: directed vector table, hand-written reset/stray sequences,
// and randomized loads checked against a behavioural memory and lane model.
module tb_param_load_unit;

  localparam int XLEN      = 64;
  localparam int ADDR_W    = 64;
  localparam int MEM_DEPTH = 32;
  localparam int TIMEOUT   = 15;
  localparam int NVEC      = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [4:0]  mem_word_addr;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic [1:0]  resp_err;

  logic [63:0] mem [MEM_DEPTH];
  int          tests = 0;
  int          failed = 0;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    int          issue_delay;
    int          resp_delay;
    int          ready_delay;
    bit          stray;
    logic [63:0] exp_data;
    logic [1:0]  exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [NVEC];

  param_load_unit #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_word_addr(mem_word_addr), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_word_addr];

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the bench's own memory image.
  function automatic vec_t build_vec(input logic [63:0] addr, input logic [1:0] size, input logic uns,
                                     input int issue_delay, input int resp_delay,
                                     input int ready_delay, input bit stray);
    vec_t v;
    logic [63:0] nbytes;
    logic [63:0] val;
    logic [63:0] mask;
    v.addr = addr; v.size = size; v.uns = uns;
    v.issue_delay = issue_delay; v.resp_delay = resp_delay;
    v.ready_delay = ready_delay; v.stray = stray;
    v.exp_data = '0;
    nbytes = 64'd1 << size;
    if ((addr % nbytes) != 0 || nbytes > 8) v.exp_err = 2'd1;
    else if ((addr / 8) >= MEM_DEPTH) v.exp_err = 2'd2;
    else if (resp_delay < 0 || resp_delay >= TIMEOUT) v.exp_err = 2'd3;
    else begin
      v.exp_err = 2'd0;
      val = mem[5'(addr >> 3)] >> (8 * (addr % 8));
      if (nbytes < 8) begin
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        val = val & mask;
        if (!uns && val[6'(8 * nbytes - 1)]) val = val | ~mask;
      end
      v.exp_data = val;
    end
    if (v.exp_err == 2'd1 || v.exp_err == 2'd2) v.exp_lat = 1;
    else v.exp_lat = issue_delay + 1 + ((v.exp_err == 2'd3) ? TIMEOUT : resp_delay + 1) + 1;
    return v;
  endfunction

  // Runs one load starting at a negedge with the unit idle; returns at the negedge after the response handshake.
  task automatic apply_stimulus(input vec_t v);
    int k;
    int icnt;
    int widx;
    bit hs;
    bit seen_req;
    logic [63:0] exp_idx;
    exp_idx = (v.addr >> 3) & 64'd31;
    k = 1; icnt = 0; widx = 0; hs = 0; seen_req = 0;
    check_output("accept_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = v.addr; req_size = v.size; req_unsigned = v.uns;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && k < 200) begin
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      if (mem_req_valid) begin
        seen_req = 1;
        check_output("issue_addr", mem_word_addr, exp_idx);
        mem_req_ready = (icnt >= v.issue_delay);
        icnt++;
        if (mem_req_ready) hs = 1;
      end else if (hs) begin
        mem_resp_valid = (v.resp_delay >= 0 && widx == v.resp_delay);
        widx++;
      end
      @(negedge clk);
      k++;
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    check_output("latency", 64'(k), 64'(v.exp_lat));
    check_output("mem_touched", 64'(seen_req), 64'(v.exp_err == 2'd0 || v.exp_err == 2'd3));
    if (seen_req) check_output("issue_cycles", 64'(icnt), 64'(v.issue_delay + 1));
    if (!resp_valid) return;
    for (int h = 0; h <= v.ready_delay; h++) begin
      check_output("resp_valid_hold", resp_valid, 1);
      check_output("resp_data", resp_data, v.exp_data);
      check_output("resp_err", resp_err, 64'(v.exp_err));
      check_output("req_ready_in_resp", req_ready, 0);
      mem_resp_valid = v.stray;
      resp_ready = (h == v.ready_delay);
      @(negedge clk);
    end
    resp_ready = 1'b0;
    mem_resp_valid = 1'b0;
    check_output("resp_valid_drop", resp_valid, 0);
    check_output("idle_ready", req_ready, 1);
  endtask

  task automatic stray_idle_check();
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid = 1'b1;
      @(negedge clk);
      check_output("stray_resp_valid", resp_valid, 0);
      check_output("stray_mem_req", mem_req_valid, 0);
      check_output("stray_req_ready", req_ready, 1);
    end
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    vec_t rv;
    logic [63:0] addr;
    logic [1:0]  size;
    int          rdel;

    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = {$urandom, $urandom};
    mem[1]  = 64'h8877_6655_4433_2211;
    mem[31] = 64'h0123_4567_89AB_CDEF;

    vecs[0]  = '{64'h0F,  2'd0, 1'b0, 0,  0, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FF88, 2'd0, 3};
    vecs[1]  = '{64'h0A,  2'd1, 1'b1, 0,  0, 0, 1'b0, 64'h0000_0000_0000_4433, 2'd0, 3};
    vecs[2]  = '{64'h0C,  2'd2, 1'b0, 0,  0, 0, 1'b0, 64'hFFFF_FFFF_8877_6655, 2'd0, 3};
    vecs[3]  = '{64'h06,  2'd2, 1'b0, 0,  0, 0, 1'b0, 64'h0,                   2'd1, 1};
    vecs[4]  = '{64'h100, 2'd3, 1'b0, 0,  0, 0, 1'b0, 64'h0,                   2'd2, 1};
    vecs[5]  = '{64'h08,  2'd3, 1'b1, 4, -1, 0, 1'b1, 64'h0,                   2'd3, 21};
    vecs[6]  = '{64'h08,  2'd3, 1'b1, 0, 14, 0, 1'b0, 64'h8877_6655_4433_2211, 2'd0, 17};
    vecs[7]  = '{64'h08,  2'd3, 1'b1, 0, 15, 0, 1'b0, 64'h0,                   2'd3, 17};
    vecs[8]  = '{64'h0E,  2'd1, 1'b0, 0,  0, 5, 1'b1, 64'hFFFF_FFFF_FFFF_8877, 2'd0, 3};
    vecs[9]  = '{64'h0F,  2'd0, 1'b1, 1,  2, 0, 1'b0, 64'h0000_0000_0000_0088, 2'd0, 6};
    vecs[10] = '{64'h101, 2'd3, 1'b0, 0,  0, 0, 1'b0, 64'h0,                   2'd1, 1};
    vecs[11] = '{64'hF8,  2'd3, 1'b0, 0,  0, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 2'd0, 3};

    repeat (2) @(negedge clk);
    check_output("reset_req_ready", req_ready, 0);
    check_output("reset_mem_req", mem_req_valid, 0);
    check_output("reset_resp_valid", resp_valid, 0);
    check_output("reset_resp_data", resp_data, 0);
    check_output("reset_resp_err", resp_err, 0);
    check_output("reset_word_addr", mem_word_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i]);
      if (i == 5) stray_idle_check();
    end

    // Reset in the middle of a WAIT that never completes.
    req_valid = 1'b1; req_addr = 64'h10; req_size = 2'd3; req_unsigned = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_output("rst_issue", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_pre_resp", resp_valid, 0);
    check_output("rst_pre_addr", mem_word_addr, 2);
    reset = 1'b1;
    #1;
    check_output("rst_req_ready", req_ready, 0);
    check_output("rst_mem_req", mem_req_valid, 0);
    check_output("rst_resp_valid", resp_valid, 0);
    check_output("rst_resp_data", resp_data, 0);
    check_output("rst_resp_err", resp_err, 0);
    check_output("rst_word_addr", mem_word_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("rst_after_ready", req_ready, 1);
    check_output("rst_after_resp", resp_valid, 0);
    apply_stimulus(build_vec(64'h10, 2'd3, 1'b1, 0, 0, 0, 1'b0));

    for (int n = 0; n < 40; n++) begin
      size = 2'($urandom_range(0, 3));
      addr = 64'($urandom_range(0, 35)) * 8 + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) addr = addr & ~((64'd1 << size) - 64'd1);
      rdel = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      rv = build_vec(addr, size, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), rdel,
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      apply_stimulus(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
